// File: rtl/sextium_io_port.sv
// rtl/sextium_io_port.sv - Sextium core I/O port: four-phase core handshake bridged to device-side read and write FIFOs.
module sextium_io_port #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_read,
    input  logic                       io_write,
    inout  wire  [15:0]                io_bus,
    output logic                       ioack,
    input  logic                       in_valid,
    input  logic [15:0]                in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [15:0]                out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     in_count,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ACK  = 2'd1,
        WR_ACK  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic        rd_accept, wr_accept, perr_set;
    logic [15:0] rd_hold;

    logic [15:0] in_mem [DEPTH];
    logic [PW-1:0] in_wp, in_rp;
    logic        in_push, in_pop;

    logic [15:0] out_mem [DEPTH];
    logic [PW-1:0] out_wp, out_rp;
    logic        out_push, out_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Only IDLE accepts a transfer; a conflicting request is flagged and ignored.
    always_comb begin
        state_nx  = state;
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        perr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (io_read && io_write) begin
                    perr_set = 1'b1;
                end else if (io_read && in_count != '0) begin
                    rd_accept = 1'b1;
                    state_nx  = RD_ACK;
                end else if (io_write && out_count != FULL) begin
                    wr_accept = 1'b1;
                    state_nx  = WR_ACK;
                end
            end
            RD_ACK:  state_nx = RELEASE;
            WR_ACK:  state_nx = RELEASE;
            RELEASE: begin
                if (!io_read && !io_write) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Decoded from the state register so an asynchronous reset drops them at once.
    assign ioack  = (state == RD_ACK) || (state == WR_ACK);
    assign io_bus = (state == RD_ACK) ? rd_hold : 16'hzzzz;

    assign in_ready  = (in_count != FULL);
    assign in_push   = in_valid && in_ready;
    assign in_pop    = rd_accept;

    assign out_valid = (out_count != '0);
    assign out_data  = out_mem[out_rp];
    assign out_push  = wr_accept;
    assign out_pop   = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (in_push) begin
            in_mem[in_wp] <= in_data;
        end
        if (out_push) begin
            out_mem[out_wp] <= io_bus;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_wp     <= '0;
            in_rp     <= '0;
            in_count  <= '0;
            out_wp    <= '0;
            out_rp    <= '0;
            out_count <= '0;
            rd_hold   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (in_push) begin
                in_wp <= in_wp + PW'(1);
            end
            if (in_pop) begin
                in_rp   <= in_rp + PW'(1);
                rd_hold <= in_mem[in_rp];
            end
            if (in_push && !in_pop) begin
                in_count <= in_count + CW'(1);
            end else if (!in_push && in_pop) begin
                in_count <= in_count - CW'(1);
            end

            if (out_push) begin
                out_wp <= out_wp + PW'(1);
            end
            if (out_pop) begin
                out_rp <= out_rp + PW'(1);
            end
            if (out_push && !out_pop) begin
                out_count <= out_count + CW'(1);
            end else if (!out_push && out_pop) begin
                out_count <= out_count - CW'(1);
            end

            if (perr_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sextium_io_port.sv
// tb/tb_sextium_io_port.sv - Self-checking bench for sextium_io_port: vector table, directed corner cases, random vs queue model.
module tb_sextium_io_port;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_read, io_write;
    wire  [15:0]   io_bus;
    logic [15:0]   bus_drv;
    logic          bus_en;
    logic          ioack;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          out_valid;
    logic [15:0]   out_data;
    logic          out_ready;
    logic [CW-1:0] in_count, out_count;
    logic          proto_err;

    assign io_bus = bus_en ? bus_drv : 16'hzzzz;

    always #5 clock = ~clock;

    sextium_io_port #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_read   (io_read),
        .io_write  (io_write),
        .io_bus    (io_bus),
        .ioack     (ioack),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .in_count  (in_count),
        .out_count (out_count),
        .proto_err (proto_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Behavioural reference: two queues plus "ack owed" and "waiting for release" flags.
    int rq[$];
    int wq[$];
    int m_ack;
    bit m_rel;
    bit m_perr;
    int m_val;

    task automatic model_reset;
        rq.delete();
        wq.delete();
        m_ack  = 0;
        m_rel  = 1'b0;
        m_perr = 1'b0;
        m_val  = 0;
    endtask

    task automatic model_edge;
        int rsz;
        int wsz;
        bit take_rd;
        bit take_wr;
        rsz = rq.size();
        wsz = wq.size();
        take_rd = 1'b0;
        take_wr = 1'b0;
        if (m_ack != 0) begin
            m_ack = 0;
            m_rel = 1'b1;
        end else if (m_rel) begin
            if (!io_read && !io_write) m_rel = 1'b0;
        end else if (io_read && io_write) begin
            m_perr = 1'b1;
        end else if (io_read && rsz > 0) begin
            take_rd = 1'b1;
        end else if (io_write && wsz < DEPTH) begin
            take_wr = 1'b1;
        end
        if (out_ready && wsz > 0) void'(wq.pop_front());
        if (take_wr) begin
            wq.push_back(int'(io_bus));
            m_ack = 2;
        end
        if (take_rd) begin
            m_val = rq.pop_front();
            m_ack = 1;
        end
        if (in_valid && rsz < DEPTH) rq.push_back(int'(in_data));
    endtask

    task automatic model_check;
        chk("rnd_ioack", int'(ioack), int'(m_ack != 0));
        chk("rnd_in_ready", int'(in_ready), int'(rq.size() < DEPTH));
        chk("rnd_out_valid", int'(out_valid), int'(wq.size() > 0));
        chk("rnd_in_count", int'(in_count), rq.size());
        chk("rnd_out_count", int'(out_count), wq.size());
        chk("rnd_proto_err", int'(proto_err), int'(m_perr));
        if (wq.size() > 0) chk("rnd_out_data", int'(out_data), wq[0]);
        if (m_ack == 1) chk("rnd_io_bus", int'(io_bus), m_val);
    endtask

    task automatic idle_inputs;
        io_read   = 1'b0;
        io_write  = 1'b0;
        bus_en    = 1'b0;
        bus_drv   = 16'h0000;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic push_in(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic core_write(input logic [15:0] d);
        int n;
        io_write = 1'b1;
        bus_drv  = d;
        bus_en   = 1'b1;
        for (n = 0; n < 20; n++) begin
            #1;
            if (ioack) break;
            tick();
        end
        chk("wr_ack_seen", int'(ioack), 1);
        io_write = 1'b0;
        bus_en   = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic [15:0] bus;
        int          e_ack;
        int          e_bus;
        int          e_in;
        int          e_out;
        int          e_perr;
        int          e_od;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_ioack", int'(ioack), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_count", int'(in_count), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        apply_reset();

        // Single read of 0x1234, single write of 0xABCD, then a conflicting request.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 0, -1, 0, 0, 0, -1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, -1, 1, 0, 0, -1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 'h1234, 0, 0, 0, -1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, -1, 0, 0, 0, -1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, -1, 0, 0, 0, -1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hABCD, 0, -1, 0, 0, 0, -1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hABCD, 1, -1, 0, 1, 0, 'hABCD};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 0, -1, 0, 1, 0, 'hABCD};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, -1, 0, 0, 0, -1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, -1, 0, 0, 1, -1};
        for (int i = 0; i < 10; i++) begin
            io_read   = tbl[i].rd;
            io_write  = tbl[i].wr;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            bus_drv   = tbl[i].bus;
            bus_en    = tbl[i].wr;
            #1;
            chk($sformatf("tbl%0d_ioack", i), int'(ioack), tbl[i].e_ack);
            chk($sformatf("tbl%0d_in_count", i), int'(in_count), tbl[i].e_in);
            chk($sformatf("tbl%0d_out_count", i), int'(out_count), tbl[i].e_out);
            chk($sformatf("tbl%0d_proto_err", i), int'(proto_err), tbl[i].e_perr);
            if (tbl[i].e_bus >= 0) chk($sformatf("tbl%0d_io_bus", i), int'(io_bus), tbl[i].e_bus);
            if (tbl[i].e_od >= 0) chk($sformatf("tbl%0d_out_data", i), int'(out_data), tbl[i].e_od);
            tick();
        end

        // Read stalls on an empty FIFO, then no repeat ack while io_read stays high.
        apply_reset();
        io_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("empty_wait_ioack", int'(ioack), 0);
            tick();
        end
        push_in(16'hBEEF);
        #1;
        chk("beef_accept_ioack", int'(ioack), 0);
        chk("beef_in_count", int'(in_count), 1);
        tick();
        #1;
        chk("beef_ioack", int'(ioack), 1);
        chk("beef_io_bus", int'(io_bus), 'hBEEF);
        chk("beef_in_count_after", int'(in_count), 0);
        push_in(16'h5555);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("held_read_ioack", int'(ioack), 0);
            chk("held_read_in_count", int'(in_count), 1);
            tick();
        end
        io_read = 1'b0;
        tick();
        tick();
        io_read = 1'b1;
        tick();
        #1;
        chk("reread_ioack", int'(ioack), 1);
        chk("reread_io_bus", int'(io_bus), 'h5555);
        io_read = 1'b0;
        tick();
        tick();

        // Write FIFO fills, fifth write stalls until one device-side pop.
        apply_reset();
        for (int k = 1; k <= 4; k++) core_write(16'(k));
        #1;
        chk("wfull_out_count", int'(out_count), 4);
        io_write = 1'b1;
        bus_drv  = 16'h0005;
        bus_en   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wfull_stall_ioack", int'(ioack), 0);
            tick();
        end
        chk("wfull_head", int'(out_data), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("wpop_ioack", int'(ioack), 0);
        chk("wpop_out_count", int'(out_count), 3);
        chk("wpop_head", int'(out_data), 2);
        tick();
        #1;
        chk("w5_ioack", int'(ioack), 1);
        chk("w5_out_count", int'(out_count), 4);
        io_write  = 1'b0;
        bus_en    = 1'b0;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            #1;
            chk($sformatf("drain_%0d", k), int'(out_data), k);
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("drain_out_count", int'(out_count), 0);
        chk("drain_out_valid", int'(out_valid), 0);

        // Conflicting request: sticky error, nothing transferred.
        apply_reset();
        push_in(16'h1111);
        push_in(16'h2222);
        core_write(16'h3333);
        io_read  = 1'b1;
        io_write = 1'b1;
        bus_drv  = 16'hFFFF;
        bus_en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("conflict_ioack", int'(ioack), 0);
            tick();
        end
        chk("conflict_proto_err", int'(proto_err), 1);
        chk("conflict_in_count", int'(in_count), 2);
        chk("conflict_out_count", int'(out_count), 1);
        idle_inputs();
        tick();
        #1;
        chk("conflict_sticky", int'(proto_err), 1);

        // Full read FIFO refuses a same-cycle push, then async reset in RD_ACK.
        apply_reset();
        for (int k = 0; k < 4; k++) push_in(16'hA000 + 16'(k));
        #1;
        chk("rfull_in_ready", int'(in_ready), 0);
        chk("rfull_in_count", int'(in_count), 4);
        in_valid = 1'b1;
        in_data  = 16'h9999;
        io_read  = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("rdack_ioack", int'(ioack), 1);
        chk("rdack_io_bus", int'(io_bus), 'hA000);
        chk("rdack_no_bypass", int'(in_count), 3);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_ioack", int'(ioack), 0);
        chk("arst_in_count", int'(in_count), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        bus_drv = 16'h5A5A;
        bus_en  = 1'b1;
        #1;
        chk("arst_bus_released", int'(io_bus), 'h5A5A);
        bus_en = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        push_in(16'h7777);
        #1;
        chk("post_rst_accept_ioack", int'(ioack), 0);
        tick();
        #1;
        chk("post_rst_ioack", int'(ioack), 1);
        chk("post_rst_io_bus", int'(io_bus), 'h7777);
        io_read = 1'b0;
        tick();
        tick();

        // Random traffic against the queue model.
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            io_read   = (r < 80) || (r == 199);
            io_write  = (r >= 80 && r < 160) || (r == 199);
            bus_drv   = 16'($urandom);
            bus_en    = io_write && (m_ack != 1);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 4);
            #1;
            model_check();
            model_edge();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sextium_io_port.md
SEXTIUM_IO_PORT -- requirements
Module: sextium_io_port

Interface
REQ-001 Parameter: DEPTH, 4, entries per FIFO (power of two, at least 2).
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 io_read  input  1  core read request, held high until ioack is seen.
REQ-005 io_write  input  1  core write request, held high until ioack is seen; write data is on io_bus.
REQ-006 io_bus  inout  16  driven by the port only in state RD_ACK, high-Z otherwise.
REQ-007 ioack  output  1  one-cycle acknowledge to the core.
REQ-008 in_valid, in_data[15:0], in_ready  input/input/output  1/16/1  device-side push into the read FIFO (data going to the core).
REQ-009 out_valid, out_data[15:0], out_ready  output/output/input  1/16/1  device-side pop from the write FIFO (data coming from the core).
REQ-010 in_count, out_count  output  $clog2(DEPTH)+1 each  current FIFO occupancy.
REQ-011 proto_err  output  1  sticky protocol-error flag.

Function
REQ-012 The port SHALL have FSM states IDLE, RD_ACK, WR_ACK and RELEASE, all registered.
REQ-013 IDLE with io_read=1, io_write=0 and read FIFO not empty: SHALL pop the FIFO head into rd_hold and go to RD_ACK.
REQ-014 RD_ACK: SHALL assert ioack=1, drive io_bus=rd_hold for exactly that cycle, then go to RELEASE.
REQ-015 IDLE with io_write=1, io_read=0 and write FIFO not full: SHALL push io_bus into the write FIFO and go to WR_ACK.
REQ-016 WR_ACK: SHALL assert ioack=1 for exactly that cycle, then go to RELEASE.
REQ-017 RELEASE: SHALL stay until io_read=0 and io_write=0 are sampled, then go to IDLE; no new request is accepted before that.
REQ-018 Latency: ioack SHALL appear in the cycle after the request is accepted in IDLE, i.e. 1 cycle unstalled.
REQ-019 Read with the read FIFO empty: SHALL stall in IDLE with ioack=0 until an entry exists; acceptance follows on the first cycle the FIFO is non-empty.
REQ-020 Write with the write FIFO full: SHALL stall in IDLE until a device-side pop frees an entry.
REQ-021 io_read=1 and io_write=1 together in IDLE: SHALL set proto_err=1, accept neither, send no ioack and stay in IDLE.
REQ-022 Read FIFO ready rule: in_ready SHALL equal (in_count != DEPTH).
REQ-023 Read FIFO push: SHALL occur on in_valid and in_ready; there is no bypass when full, even with a same-cycle core pop.
REQ-024 Write FIFO valid rule: out_valid SHALL equal (out_count != 0), with out_data = head combinationally.
REQ-025 Write FIFO pop: SHALL occur on out_valid and out_ready.
REQ-026 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the count unchanged and preserve FIFO order.
REQ-027 FIFO read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; counts SHALL never exceed DEPTH or drop below 0.
REQ-028 ioack SHALL never be high in IDLE or RELEASE, and never high on two consecutive cycles.

Reset
REQ-029 On reset=1 (asynchronous) the port SHALL set state=IDLE, ioack=0, io_bus=Z, in_count=out_count=0, all pointers=0, rd_hold=0, proto_err=0, in_ready=1 and out_valid=0.
REQ-030 Reset mid-handshake SHALL discard the transfer and all FIFO contents.
REQ-031 A request still high when reset releases SHALL be treated as a new request in IDLE.

Verification
REQ-032 Push 0x1234 via in_*, then hold io_read -> ioack high exactly 1 cycle after acceptance with io_bus=0x1234, then in_count=0.
REQ-033 Hold io_read with the read FIFO empty for 10 cycles, then push 0xBEEF -> no ioack during the wait, then ioack with io_bus=0xBEEF.
REQ-034 Perform 4 core writes 0x0001..0x0004 with out_ready=0, then a fifth write 0x0005 -> fifth is stalled, no ioack; raise out_ready -> out_data pops in order 0x0001.., and the fifth write is acked after the first pop.
REQ-035 Assert io_read and io_write together -> proto_err=1 stays set, no ioack, FIFOs unchanged.
REQ-036 Keep io_read high after ioack -> no second ioack until io_read drops and rises again.
REQ-037 Assert reset during RD_ACK with in_count=3 -> ioack=0, io_bus=Z and in_count=0 immediately, without waiting for a clock edge.
